exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width.
REQ-002 clk  in  1  rising-edge clock, the single clock of the block.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1 / in_ready  out  1  SHALL form the instruction-accept handshake.
REQ-005 opcode  in  7 / func3  in  3 / func7  in  7  SHALL carry the decoded instruction fields.
REQ-006 valA  in  XLEN / valB  in  XLEN  SHALL carry the register operands (rs1, rs2).
REQ-007 alu_valE  in  XLEN / alu_cond  in  1 / alu_fault  in  1  SHALL carry the combinational execute-datapath results for the current inputs.
REQ-008 flush  in  1  SHALL be a synchronous abort request.
REQ-009 out_valid  out  1 / out_ready  in  1  SHALL form the result handshake.
REQ-010 valE  out  XLEN / cond  out  1 / inst_fault  out  1  SHALL be registered results.
REQ-011 busy  out  1  SHALL be high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ITER, and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; accept occurs on a clock edge where in_valid and in_ready are both high.
REQ-014 On accepting a non-M instruction, the block SHALL register alu_valE, alu_cond, and alu_fault and go to DONE; out_valid SHALL rise 1 cycle after accept.
REQ-015 An M instruction SHALL be opcode OP (0110011) with func7 = 0000001; func3 SHALL select MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, or REMU (0..7).
REQ-016 On accepting an M instruction, the block SHALL latch operand magnitudes and result-sign flags, clear a log2(XLEN)+1-bit counter, and go to ITER.
REQ-017 In ITER, the block SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle for exactly XLEN cycles, then apply the sign correction and go to DONE; out_valid SHALL rise XLEN+1 cycles after accept.
REQ-018 Multiply SHALL form the full 2*XLEN product; MUL SHALL return the low half; MULH, MULHSU, and MULHU SHALL return the high half with signed×signed, signed×unsigned, and unsigned×unsigned operand interpretation respectively.
REQ-019 For division by zero, the block SHALL return quotient all-ones and remainder = valA, and SHALL go directly to DONE (1-cycle latency).
REQ-020 For signed overflow (valA = most-negative value, valB = -1), DIV SHALL return valA and REM SHALL return 0, via the 1-cycle path.
REQ-021 Remainder sign SHALL follow the dividend; quotient SHALL round toward zero.
REQ-022 For M instructions, cond SHALL be 0 and inst_fault SHALL be 0.
REQ-023 In DONE, out_valid SHALL be 1 and outputs SHALL be held stable until out_ready is high; on out_ready the FSM SHALL go to IDLE.
REQ-024 Accept and result handoff SHALL never coincide, because in_ready is 0 in DONE.
REQ-025 flush SHALL force IDLE on the next edge from any state and SHALL discard any in-progress or undelivered result; flush takes priority over accept and over out_ready.
REQ-026 Inputs other than handshake, flush, and out_ready SHALL be ignored outside IDLE.

Reset
REQ-027 rst SHALL immediately force state IDLE, counter 0, out_valid 0, valE 0, cond 0, inst_fault 0, and busy 0; in_ready SHALL be 1 after reset.
REQ-028 Reset asserted during ITER or DONE SHALL drop the operation and produce no result.

Configuration
REQ-029 With RV32M_EN defined, the M path (REQ-015..REQ-022) SHALL be present.
REQ-030 Without RV32M_EN, no iterative datapath SHALL be built, ITER SHALL be unreachable, and M encodings SHALL take the non-M path, reporting alu_fault (1 from the datapath) with 1-cycle latency.

Verification
REQ-031 ADD, alu_valE=0x0000_0005, out_ready=1 -> out_valid 1 cycle after accept, valE=5, cond 0, inst_fault 0.
REQ-032 RV32M_EN, MULH valA=0xFFFF_FFFE (-2), valB=0x0000_0003 -> out_valid after 33 cycles, valE=0xFFFF_FFFF; MULHU same operands -> valE=0x0000_0002.
REQ-033 RV32M_EN, DIV valA=0xFFFF_FFF9 (-7), valB=2 -> valE=0xFFFF_FFFD; REM -> 0xFFFF_FFFF; DIVU valB=0 -> 0xFFFF_FFFF after 1 cycle; DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 after 1 cycle.
REQ-034 out_ready held low 5 cycles in DONE -> out_valid and valE stable, in_ready 0; no new accept until the cycle after handoff.
REQ-035 flush at ITER cycle 10 -> IDLE next cycle, out_valid never rises, in_ready 1; async rst mid-ITER -> outputs 0 immediately.
REQ-036 No RV32M_EN, MUL with alu_fault=1 -> out_valid after 1 cycle, inst_fault 1, busy never high beyond DONE.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: execute-stage sequencer, single-cycle ALU path plus an
// optional iterative multiply/divide unit built when RV32M_EN is defined.
module exec_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] valA,
  input  logic [XLEN-1:0] valB,
  input  logic [XLEN-1:0] alu_valE,
  input  logic            alu_cond,
  input  logic            alu_fault,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] valE,
  output logic            cond,
  output logic            inst_fault,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state, state_nx;
  logic            accept;
  logic            is_m;
  logic            m_fast;
  logic [XLEN-1:0] m_fast_val;
  logic            iter_last;
  logic            unused_bits;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

`ifdef RV32M_EN
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   hi, lo, dvs;
  logic              neg;
  logic [2:0]        op;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     add_s;
  logic [XLEN+1:0]   sub_s;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   qr, qr_c, fin;

  assign is_m = (opcode == 7'b0110011) && (func7 == 7'b0000001);
  assign sa = valA[XLEN-1] &&
    (func3 == 3'd1 || func3 == 3'd2 || func3 == 3'd4 || func3 == 3'd6);
  assign sb = valB[XLEN-1] &&
    (func3 == 3'd1 || func3 == 3'd4 || func3 == 3'd6);
  assign a_mag = sa ? -valA : valA;
  assign b_mag = sb ? -valB : valB;

  // Divide by zero and signed overflow bypass the iteration entirely
  always_comb begin
    m_fast     = 1'b0;
    m_fast_val = '0;
    if (func3[2]) begin
      if (valB == '0) begin
        m_fast     = 1'b1;
        m_fast_val = func3[1] ? valA : '1;
      end else if (!func3[0] && valA == MINV && valB == '1) begin
        m_fast     = 1'b1;
        m_fast_val = func3[1] ? '0 : valA;
      end
    end
  end

  assign iter_last = (cnt == CW'(XLEN));
  assign add_s = lo[0] ? ({1'b0, hi} + {1'b0, dvs}) : {1'b0, hi};
  assign sub_s = {1'b0, hi, lo[XLEN-1]} - {2'b00, dvs};
  assign prod_c = neg ? -{hi, lo} : {hi, lo};
  assign qr = op[1] ? hi : lo;
  assign qr_c = neg ? -qr : qr;
  assign fin = op[2] ? qr_c :
               (op[1:0] == 2'd0) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
  assign unused_bits = sub_s[XLEN];

  // Shift-add / restoring-divide datapath, one step per ITER cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
      dvs <= '0;
      neg <= 1'b0;
      op  <= '0;
    end else if (accept && is_m) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= func3[2] ? a_mag : b_mag;
      dvs <= func3[2] ? b_mag : a_mag;
      neg <= (func3[2] && func3[1]) ? sa : (sa ^ sb);
      op  <= func3;
    end else if (state == ITER && !iter_last) begin
      cnt <= cnt + 1'b1;
      if (op[2]) begin
        if (!sub_s[XLEN+1]) begin
          hi <= sub_s[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= {hi[XLEN-2:0], lo[XLEN-1]};
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi, lo} <= {add_s, lo[XLEN-1:1]};
      end
    end
  end
`else
  assign is_m        = 1'b0;
  assign m_fast      = 1'b0;
  assign m_fast_val  = '0;
  assign iter_last   = 1'b0;
  assign unused_bits = ^{opcode, func3, func7, valA, valB};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; flush overrides accept and handoff
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (is_m && !m_fast) ? ITER : DONE;
      ITER: if (iter_last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Result registers, held while DONE waits for out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valE       <= '0;
      cond       <= 1'b0;
      inst_fault <= 1'b0;
    end else if (accept) begin
      valE       <= is_m ? m_fast_val : alu_valE;
      cond       <= is_m ? 1'b0 : alu_cond;
      inst_fault <= is_m ? 1'b0 : alu_fault;
`ifdef RV32M_EN
    end else if (state == ITER && iter_last) begin
      valE       <= fin;
      cond       <= 1'b0;
      inst_fault <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: randomized self-checking bench for exec_sequencer.
// Exercises the M path only when RV32M_EN is defined.
module tb_exec_sequencer;

  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] F7_M  = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [31:0] valA = '0;
  logic [31:0] valB = '0;
  logic [31:0] alu_valE = '0;
  logic        alu_cond = 1'b0;
  logic        alu_fault = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] valE;
  logic        cond;
  logic        inst_fault;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  exec_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .func7(func7),
    .valA(valA), .valB(valB),
    .alu_valE(alu_valE), .alu_cond(alu_cond), .alu_fault(alu_fault),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .valE(valE), .cond(cond), .inst_fault(inst_fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic scramble();
    opcode = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
    valA = $urandom; valB = $urandom; alu_valE = $urandom;
    alu_cond = 1'($urandom); alu_fault = 1'($urandom);
  endtask

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ae,
                        input logic ac, input logic af, output int lat);
    opcode = op; func3 = f3; func7 = f7; valA = a; valB = b;
    alu_valE = ae; alu_cond = ac; alu_fault = af;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [6:0] rand_alu_f7(input logic [6:0] op);
    logic [6:0] f7;
    f7 = 7'($urandom);
    if (op == OP_OP && f7 == F7_M) f7 = 7'd0;
    return f7;
  endfunction

  // Arithmetic reference for the M extension using 64-bit math
  function automatic logic [31:0] m_model(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    case (f3)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int m_lat(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b);
    if (f3 >= 3'd4 && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid, busy, valE, cond, inst_fault} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0})
      $display("FAIL reset_state got rdy=%b ov=%b busy=%b valE=%h c=%b f=%b",
               in_ready, out_valid, busy, valE, cond, inst_fault);
    else pass_cnt++;
  endtask

  task automatic test_alu_random();
    int lat;
    logic [6:0] op;
    logic [31:0] ae;
    logic ac, af;
    for (int i = 0; i < 16; i++) begin
      op = (i == 0) ? OP_OP : 7'($urandom);
      ae = (i == 0) ? 32'd5 : $urandom;
      ac = (i == 0) ? 1'b0 : 1'($urandom);
      af = (i == 0) ? 1'b0 : 1'($urandom);
      run_op(op, 3'($urandom), (i == 0) ? 7'd0 : rand_alu_f7(op),
             $urandom, $urandom, ae, ac, af, lat);
      total_cnt++;
      if (lat !== 1) $display("FAIL alu_latency[%0d] got %0d want 1", i, lat);
      else pass_cnt++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      total_cnt++;
      if ({out_valid, valE, cond, inst_fault} !== {1'b1, ae, ac, af})
        $display("FAIL alu_result[%0d] got ov=%b %h %b %b want 1 %h %b %b",
                 i, out_valid, valE, cond, inst_fault, ae, ac, af);
      else pass_cnt++;
      handoff();
      total_cnt++;
      if ({out_valid, busy, in_ready} !== 3'b001)
        $display("FAIL alu_handoff[%0d] got %b want 001", i,
                 {out_valid, busy, in_ready});
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] ae1, ae2;
    ae1 = $urandom; ae2 = ~ae1;
    run_op(7'b0010011, 3'd0, 7'd0, 0, 0, ae1, 1'b1, 1'b0, lat);
    opcode = 7'b0010011; func7 = 7'd0; alu_valE = ae2;
    alu_cond = 1'b0; alu_fault = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({out_valid, in_ready, valE} !== {1'b1, 1'b0, ae1})
        $display("FAIL hold[%0d] got ov=%b rdy=%b %h want 1 0 %h",
                 i, out_valid, in_ready, valE, ae1);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    handoff();
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL no_accept_on_handoff got %b want 01",
               {out_valid, in_ready});
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, valE, cond} !== {1'b1, ae2, 1'b0})
      $display("FAIL next_accept got ov=%b %h %b want 1 %h 0",
               out_valid, valE, cond, ae2);
    else pass_cnt++;
    handoff();
  endtask

  task automatic test_flush();
    int lat;
    in_valid = 1'b1; flush = 1'b1; opcode = 7'b0110111; func7 = 7'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total_cnt++;
    if ({busy, out_valid, in_ready} !== 3'b001)
      $display("FAIL flush_over_accept got %b want 001",
               {busy, out_valid, in_ready});
    else pass_cnt++;
    run_op(7'b0010011, 3'd1, 7'd0, 0, 0, 32'h1234_5678, 1'b0, 1'b0, lat);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if ({busy, out_valid, in_ready} !== 3'b001)
      $display("FAIL flush_done got %b want 001", {busy, out_valid, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int lat;
    logic [31:0] ae;
    ae = $urandom | 32'h1;
    run_op(7'b0010011, 3'd0, 7'd0, 0, 0, ae, 1'b1, 1'b1, lat);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, busy, in_ready, valE, cond, inst_fault} !==
        {1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0})
      $display("FAIL rst_in_done got ov=%b busy=%b rdy=%b %h %b %b",
               out_valid, busy, in_ready, valE, cond, inst_fault);
    else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef RV32M_EN
  task automatic test_m_directed();
    logic [2:0]  f3 [6] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4};
    logic [31:0] a  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd17, 32'h8000_0000};
    logic [31:0] b  [6] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd0,
                            32'hFFFF_FFFF};
    logic [31:0] ex [6] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFD,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    int          el [6] = '{33, 33, 33, 33, 1, 1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(OP_OP, f3[i], F7_M, a[i], b[i], $urandom, 1'b1, 1'b1, lat);
      total_cnt++;
      if (lat !== el[i] || {valE, cond, inst_fault} !== {ex[i], 2'b00})
        $display("FAIL m_directed[%0d] got lat=%0d %h %b%b want %0d %h 00",
                 i, lat, valE, cond, inst_fault, el[i], ex[i]);
      else pass_cnt++;
      handoff();
    end
  endtask

  task automatic test_m_random();
    int lat;
    logic [2:0] f3;
    logic [31:0] a, b;
    logic [31:0] sp [4] = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      run_op(OP_OP, f3, F7_M, a, b, $urandom, 1'b1, 1'b1, lat);
      total_cnt++;
      if (lat !== m_lat(f3, a, b) ||
          {valE, cond, inst_fault} !== {m_model(f3, a, b), 2'b00})
        $display("FAIL m_rand f3=%0d a=%h b=%h got lat=%0d %h %b%b want %0d %h",
                 f3, a, b, lat, valE, cond, inst_fault, m_lat(f3, a, b),
                 m_model(f3, a, b));
      else pass_cnt++;
      handoff();
    end
  endtask

  task automatic test_m_abort();
    bit seen;
    opcode = OP_OP; func7 = F7_M; func3 = 3'd0;
    valA = $urandom; valB = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    total_cnt++;
    if ({busy, out_valid} !== 2'b10)
      $display("FAIL iter_busy got %b want 10", {busy, out_valid});
    else pass_cnt++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total_cnt++;
    if ({busy, out_valid, in_ready} !== 3'b001)
      $display("FAIL flush_iter got %b want 001", {busy, out_valid, in_ready});
    else pass_cnt++;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL flush_iter_result got %b want 0", seen);
    else pass_cnt++;
    func3 = 3'd4; valB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, busy, in_ready, valE, cond, inst_fault} !==
        {1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0})
      $display("FAIL rst_in_iter got ov=%b busy=%b rdy=%b %h",
               out_valid, busy, in_ready, valE);
    else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rst_iter_result got %b want 0", seen);
    else pass_cnt++;
  endtask
`else
  task automatic test_m_disabled();
    int lat;
    logic [31:0] ae;
    for (int i = 0; i < 8; i++) begin
      ae = $urandom;
      run_op(OP_OP, 3'(i), F7_M, $urandom, $urandom, ae, 1'b0, 1'b1, lat);
      total_cnt++;
      if (lat !== 1 || {busy, valE, inst_fault} !== {1'b1, ae, 1'b1})
        $display("FAIL m_off[%0d] got lat=%0d busy=%b %h f=%b want 1 1 %h 1",
                 i, lat, busy, valE, inst_fault, ae);
      else pass_cnt++;
      handoff();
      total_cnt++;
      if ({busy, out_valid} !== 2'b00)
        $display("FAIL m_off_idle[%0d] got %b want 00", i, {busy, out_valid});
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_random();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef RV32M_EN
    test_m_directed();
    test_m_random();
    test_m_abort();
`else
    test_m_disabled();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
